jt89_regs: RTL and testbench

Host-bus register file for the JT89 (SN76489-compatible) PSG. Decodes latch/data byte writes from the CPU strobe, holds the three 10-bit tone periods, four 4-bit attenuations and the 3-bit noise control, and drives them straight into the tone, noise and volume stages. Generates the chip's READY back-pressure signal and a noise-LFSR reset request on every noise-control write.

---
 rtl/jt89_regs_if.sv | 11 +
 rtl/jt89_regs.sv | 135 +++++++++++++
 tb/tb_jt89_regs.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt89_regs_if.sv
// Host write bus of the JT89 register file: CPU data byte, write strobe and READY.
interface jt89_regs_if;
    localparam int unsigned DW = 8;

    logic [DW-1:0] din;
    logic          wr_n;
    logic          ready;

    modport master (output din, output wr_n, input  ready);
    modport slave  (input  din, input  wr_n, output ready);
endinterface

// File: rtl/jt89_regs.sv
// JT89 (SN76489-compatible) register file: latch/data byte decode, tone/volume/noise
// registers, READY back-pressure and noise LFSR reset request.
module jt89_regs #(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    jt89_regs_if.slave  bus,
    output logic [9:0]  tone0,
    output logic [9:0]  tone1,
    output logic [9:0]  tone2,
    output logic [3:0]  vol0,
    output logic [3:0]  vol1,
    output logic [3:0]  vol2,
    output logic [3:0]  vol3,
    output logic [2:0]  ctrl3,
    output logic        noise_rst
);
    localparam int unsigned TW    = 10;
    localparam int unsigned VW    = 4;
    localparam int unsigned CW    = 3;
    localparam int unsigned IW    = 3;
    localparam int unsigned CNT_W = (READY_CYCLES > 0) ? $clog2(READY_CYCLES + 1) : 1;

    logic [TW-1:0]    tone0_q, tone0_d, tone1_q, tone1_d, tone2_q, tone2_d;
    logic [VW-1:0]    vol0_q, vol0_d, vol1_q, vol1_d, vol2_q, vol2_d, vol3_q, vol3_d;
    logic [CW-1:0]    ctrl3_q, ctrl3_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             noise_rst_q, noise_rst_d;
    logic             ready_q, ready_d;
    logic             wr_n_q, wr_n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [IW-1:0]    tgt;

    // Latch bytes replace the low nibble of a tone, data bytes replace the upper six bits.
    function automatic logic [TW-1:0] tone_upd(input logic [TW-1:0] t, input logic [7:0] b);
        return b[7] ? {t[9:4], b[3:0]} : {b[5:0], t[3:0]};
    endfunction

    // Write detect, register decode, noise reset request and READY counter.
    always_comb begin
        wr_n_d      = bus.wr_n;
        tone0_d     = tone0_q;
        tone1_d     = tone1_q;
        tone2_d     = tone2_q;
        vol0_d      = vol0_q;
        vol1_d      = vol1_q;
        vol2_d      = vol2_q;
        vol3_d      = vol3_q;
        ctrl3_d     = ctrl3_q;
        idx_d       = idx_q;
        noise_rst_d = noise_rst_q;
        cnt_d       = cnt_q;
        accept      = ~bus.wr_n & wr_n_q & ready_q;
        tgt         = bus.din[7] ? bus.din[6:4] : idx_q;

        if (clk_en) begin
            noise_rst_d = 1'b0;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (accept) begin
            if (bus.din[7]) begin
                idx_d = tgt;
            end
            case (tgt)
                3'd0: tone0_d = tone_upd(tone0_q, bus.din);
                3'd1: vol0_d  = bus.din[3:0];
                3'd2: tone1_d = tone_upd(tone1_q, bus.din);
                3'd3: vol1_d  = bus.din[3:0];
                3'd4: tone2_d = tone_upd(tone2_q, bus.din);
                3'd5: vol2_d  = bus.din[3:0];
                3'd6: begin
                    ctrl3_d     = bus.din[2:0];
                    noise_rst_d = 1'b1;
                end
                default: vol3_d = bus.din[3:0];
            endcase
            // A write edge loads the counter; a coincident clk_en does not count.
            if (READY_CYCLES != 0) begin
                cnt_d = CNT_W'(READY_CYCLES);
            end
        end

        ready_d = (cnt_d == '0);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone0_q     <= '0;
            tone1_q     <= '0;
            tone2_q     <= '0;
            vol0_q      <= '1;
            vol1_q      <= '1;
            vol2_q      <= '1;
            vol3_q      <= '1;
            ctrl3_q     <= '0;
            idx_q       <= '0;
            noise_rst_q <= 1'b0;
            ready_q     <= 1'b1;
            wr_n_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            tone0_q     <= tone0_d;
            tone1_q     <= tone1_d;
            tone2_q     <= tone2_d;
            vol0_q      <= vol0_d;
            vol1_q      <= vol1_d;
            vol2_q      <= vol2_d;
            vol3_q      <= vol3_d;
            ctrl3_q     <= ctrl3_d;
            idx_q       <= idx_d;
            noise_rst_q <= noise_rst_d;
            ready_q     <= ready_d;
            wr_n_q      <= wr_n_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tone0     = tone0_q;
    assign tone1     = tone1_q;
    assign tone2     = tone2_q;
    assign vol0      = vol0_q;
    assign vol1      = vol1_q;
    assign vol2      = vol2_q;
    assign vol3      = vol3_q;
    assign ctrl3     = ctrl3_q;
    assign noise_rst = noise_rst_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_jt89_regs.sv
// Bench for jt89_regs: two instances (READY disabled and READY=32) against a register-map model.
module tb_jt89_regs;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int en_rand = 0;
    int en_period = 4;
    int en_ph = 0;

    jt89_regs_if bus0 ();
    jt89_regs_if bus32 ();
    assign bus0.din   = din;
    assign bus0.wr_n  = wr_n;
    assign bus32.din  = din;
    assign bus32.wr_n = wr_n;

    logic [9:0] a_t0, a_t1, a_t2, b_t0, b_t1, b_t2;
    logic [3:0] a_v0, a_v1, a_v2, a_v3, b_v0, b_v1, b_v2, b_v3;
    logic [2:0] a_c3, b_c3;
    logic       a_nr, b_nr;

    jt89_regs #(.READY_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus0.slave),
        .tone0(a_t0), .tone1(a_t1), .tone2(a_t2),
        .vol0(a_v0), .vol1(a_v1), .vol2(a_v2), .vol3(a_v3),
        .ctrl3(a_c3), .noise_rst(a_nr)
    );

    jt89_regs #(.READY_CYCLES(32)) dut32 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus32.slave),
        .tone0(b_t0), .tone1(b_t1), .tone2(b_t2),
        .vol0(b_v0), .vol1(b_v1), .vol2(b_v2), .vol3(b_v3),
        .ctrl3(b_c3), .noise_rst(b_nr)
    );

    always #5 clk = ~clk;

    // PSG tick enable: fixed period or random.
    always @(negedge clk) begin
        if (en_rand != 0) begin
            clk_en = ($urandom % 3) == 0;
        end else begin
            en_ph  = (en_ph + 1) % en_period;
            clk_en = (en_ph == 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register map held as plain arrays, one set per instance.
    int m_tone [2][3];
    int m_vol  [2][4];
    int m_ctrl [2];
    int m_idx  [2];
    int m_cnt  [2];
    int m_nrst [2];
    int m_prev [2];

    logic       s_valid = 1'b0;
    logic       s_rst, s_wr, s_en;
    logic [7:0] s_din;

    always @(posedge clk) begin
        s_valid <= 1'b1;
        s_rst   <= rst;
        s_wr    <= wr_n;
        s_en    <= clk_en;
        s_din   <= din;
    end

    task automatic step_model(input int m);
        int rc, r, t, d;
        bit acc;
        rc = (m == 0) ? 0 : 32;
        d  = int'(s_din);
        if (s_rst) begin
            for (int i = 0; i < 3; i++) m_tone[m][i] = 0;
            for (int i = 0; i < 4; i++) m_vol[m][i] = 15;
            m_ctrl[m] = 0; m_idx[m] = 0; m_cnt[m] = 0; m_nrst[m] = 0; m_prev[m] = 0;
        end else begin
            acc = (s_wr == 1'b0) && (m_prev[m] == 1) && (m_cnt[m] == 0);
            m_prev[m] = int'(s_wr);
            if (s_en) begin
                m_nrst[m] = 0;
                if (m_cnt[m] > 0) m_cnt[m] = m_cnt[m] - 1;
            end
            if (acc) begin
                r = (d >= 128) ? (d / 16) % 8 : m_idx[m];
                if (d >= 128) m_idx[m] = r;
                if (r == 6) begin
                    m_ctrl[m] = d % 8;
                    m_nrst[m] = 1;
                end else if (r % 2 == 1) begin
                    m_vol[m][r / 2] = d % 16;
                end else begin
                    t = m_tone[m][r / 2];
                    m_tone[m][r / 2] = (d >= 128) ? (t / 16) * 16 + d % 16 : (d % 64) * 16 + t % 16;
                end
                m_cnt[m] = rc;
            end
        end
    endtask

    function automatic logic [63:0] exp_vec(input int m);
        return {13'd0, 10'(m_tone[m][0]), 10'(m_tone[m][1]), 10'(m_tone[m][2]),
                4'(m_vol[m][0]), 4'(m_vol[m][1]), 4'(m_vol[m][2]), 4'(m_vol[m][3]),
                3'(m_ctrl[m]), 1'(m_nrst[m]), 1'(m_cnt[m] == 0)};
    endfunction

    // Every cycle: advance the model and compare both instances in full.
    always @(negedge clk) begin
        if (s_valid) begin
            step_model(0);
            step_model(1);
            check("dut0_state", {13'd0, a_t0, a_t1, a_t2, a_v0, a_v1, a_v2, a_v3, a_c3, a_nr, bus0.ready},
                  exp_vec(0));
            check("dut32_state", {13'd0, b_t0, b_t1, b_t2, b_v0, b_v1, b_v2, b_v3, b_c3, b_nr, bus32.ready},
                  exp_vec(1));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        din  = b;
        wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready32();
        int k = 0;
        while (bus32.ready !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        check("wait_ready32", 64'(bus32.ready), 64'd1);
    endtask

    initial begin
        int k, low;

        // Reset with the strobe held low across release: no write may happen.
        rst = 1'b1; wr_n = 1'b0; din = 8'h81;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_vol0", 64'(a_v0), 64'hF);
        check("rst_tones", {34'd0, a_t0, a_t1, a_t2}, 64'd0);
        check("rst_ctrl3", 64'(a_c3), 64'd0);
        check("rst_noise_rst", 64'(b_nr), 64'd0);
        check("rst_ready32", 64'(bus32.ready), 64'd1);
        wr_n = 1'b1;
        tick();

        // Tone writes on the READY-disabled instance.
        wr_byte(8'h8E);
        check("tone0_latch", 64'(a_t0), 64'h00E);
        wr_byte(8'h0F);
        check("tone0_data", 64'(a_t0), 64'h0FE);
        wr_byte(8'hC3);
        wr_byte(8'h3F);
        check("tone2", 64'(a_t2), 64'h3F3);
        check("tone0_kept", 64'(a_t0), 64'h0FE);
        check("tone1_kept", 64'(a_t1), 64'h000);

        // Volume latch, data byte reuse of the latched index.
        wr_byte(8'hBA);
        check("vol1_latch", 64'(a_v1), 64'hA);
        wr_byte(8'h05);
        check("vol1_data", 64'(a_v1), 64'h5);
        wr_byte(8'hFF);
        check("vol3", 64'(a_v3), 64'hF);
        check("vol0_vol2_kept", {56'd0, a_v0, a_v2}, 64'hFF);

        // Noise control and reset request, clk_en every 4 clk.
        din = 8'hE5; wr_n = 1'b0;
        tick();
        check("ctrl3_latch", 64'(a_c3), 64'd5);
        check("noise_rst_set", 64'(a_nr), 64'd1);
        wr_n = 1'b1;
        k = 0;
        while (a_nr === 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("noise_rst_clear_1to4", 64'(k >= 1 && k <= 4), 64'd1);
        din = 8'h02; wr_n = 1'b0;
        tick();
        check("ctrl3_data", 64'(a_c3), 64'd2);
        check("noise_rst_again", 64'(a_nr), 64'd1);
        wr_n = 1'b1;
        tick();

        // READY=32 busy window with an ignored strobe in the middle.
        wait_ready32();
        din = 8'h91; wr_n = 1'b0;
        tick();
        check("ready32_low", 64'(bus32.ready), 64'd0);
        check("vol0_32", 64'(b_v0), 64'h1);
        wr_n = 1'b1;
        low = 1;
        while (bus32.ready === 1'b0 && low < 300) begin
            if (low == 40) begin
                din = 8'h9C; wr_n = 1'b0;
            end else begin
                wr_n = 1'b1;
            end
            tick();
            if (bus32.ready === 1'b0) low++;
        end
        check("busy_clk_125to128", 64'(low >= 125 && low <= 128), 64'd1);
        check("busy_strobe_ignored", 64'(b_v0), 64'h1);
        wr_byte(8'h93);
        check("write_after_ready", 64'(b_v0), 64'h3);

        // rst in the middle of a busy window.
        wait_ready32();
        wr_byte(8'h9A);
        check("vol0_before_rst", 64'(b_v0), 64'hA);
        repeat (18) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midbusy_ready", 64'(bus32.ready), 64'd1);
        check("midbusy_vol0", 64'(b_v0), 64'hF);
        tick();
        din = 8'h94; wr_n = 1'b0;
        tick();
        check("post_rst_write", 64'(b_v0), 64'h4);
        check("post_rst_busy", 64'(bus32.ready), 64'd0);
        wr_n = 1'b1;
        tick();

        // Random traffic with random ticks and occasional reset.
        en_rand = 1;
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom % 200) == 0;
            wr_n = ($urandom % 3) != 0;
            din  = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        wr_n = 1'b1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
